// File: rtl/seq_stage_ctrl.sv
// Multi-cycle Y86 sequencer: walks one instruction at a time through
// FETCH..PCUPD, stalls on data memory, and halts with a Y86 status code on faults.
module seq_stage_ctrl #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  icode,
   input  logic        instr_valid,
   input  logic        imem_error,
   input  logic        mem_ready,
   input  logic        dmem_error,
   output logic        fetch_en,
   output logic        decode_en,
   output logic        execute_en,
   output logic        memory_en,
   output logic        wb_en,
   output logic        pc_en,
   output logic        cc_we,
   output logic [2:0]  stat,
   output logic        busy,
   output logic [31:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEMORY,
      S_WRITEBACK,
      S_PCUPD,
      S_HALTED
   } state_t;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;
   localparam logic [3:0] ICODE_HALT = 4'd0;
   localparam logic [3:0] ICODE_OPQ  = 4'd6;
   // The counter holds the number of wait cycles already spent, so the
   // final permitted wait cycle is seen when it equals MEM_TIMEOUT-1.
   localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

   state_t      r_state;
   state_t      w_nextState;
   logic [2:0]  r_stat;
   logic [2:0]  w_nextStat;
   logic [3:0]  r_icode;
   logic [3:0]  r_waitCnt;
   logic [31:0] r_instrCount;
   logic        r_fetchEn;
   logic        r_decodeEn;
   logic        r_executeEn;
   logic        r_memoryEn;
   logic        r_wbEn;
   logic        r_pcEn;
   logic        r_ccWe;
   logic        r_busy;
   logic        w_isMemOp;

   assign w_isMemOp = (r_icode == 4'd4) || (r_icode == 4'd5) || (r_icode == 4'd8) ||
                      (r_icode == 4'd9) || (r_icode == 4'd10) || (r_icode == 4'd11);

   always_comb begin
      w_nextState = r_state;
      w_nextStat  = r_stat;
      case (r_state)
         S_IDLE: begin
            if (start) w_nextState = S_FETCH;
         end
         S_FETCH: begin
            if (imem_error) begin
               w_nextState = S_HALTED;
               w_nextStat  = STAT_ADR;
            end else if (!instr_valid) begin
               w_nextState = S_HALTED;
               w_nextStat  = STAT_INS;
            end else begin
               w_nextState = S_DECODE;
            end
         end
         S_DECODE: w_nextState = S_EXECUTE;
         S_EXECUTE: begin
            if (w_isMemOp)                   w_nextState = S_MEMORY;
            else if (r_icode == ICODE_HALT)  w_nextState = S_PCUPD;
            else                             w_nextState = S_WRITEBACK;
         end
         S_MEMORY: begin
            // Completion is checked first so a late mem_ready still wins over the timeout.
            if (mem_ready) begin
               if (dmem_error) begin
                  w_nextState = S_HALTED;
                  w_nextStat  = STAT_ADR;
               end else begin
                  w_nextState = S_WRITEBACK;
               end
            end else if (r_waitCnt == WAIT_LAST) begin
               w_nextState = S_HALTED;
               w_nextStat  = STAT_ADR;
            end
         end
         S_WRITEBACK: w_nextState = S_PCUPD;
         S_PCUPD: begin
            if (r_icode == ICODE_HALT) begin
               w_nextState = S_HALTED;
               w_nextStat  = STAT_HLT;
            end else begin
               w_nextState = S_FETCH;
            end
         end
         S_HALTED: w_nextState = S_HALTED;
         default:  w_nextState = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with r_state
   // while never depending combinationally on the inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_stat       <= STAT_AOK;
         r_icode      <= 4'd0;
         r_waitCnt    <= 4'd0;
         r_instrCount <= 32'd0;
         r_fetchEn    <= 1'b0;
         r_decodeEn   <= 1'b0;
         r_executeEn  <= 1'b0;
         r_memoryEn   <= 1'b0;
         r_wbEn       <= 1'b0;
         r_pcEn       <= 1'b0;
         r_ccWe       <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_stat  <= w_nextStat;
         if (r_state == S_FETCH && w_nextState == S_DECODE) r_icode <= icode;
         r_waitCnt <= (r_state == S_MEMORY) ? r_waitCnt + 4'd1 : 4'd0;
         if (r_state == S_PCUPD) r_instrCount <= r_instrCount + 32'd1;
         r_fetchEn   <= (w_nextState == S_FETCH);
         r_decodeEn  <= (w_nextState == S_DECODE);
         r_executeEn <= (w_nextState == S_EXECUTE);
         r_memoryEn  <= (w_nextState == S_MEMORY);
         r_wbEn      <= (w_nextState == S_WRITEBACK);
         r_pcEn      <= (w_nextState == S_PCUPD);
         r_ccWe      <= (w_nextState == S_EXECUTE) && (r_icode == ICODE_OPQ);
         r_busy      <= (w_nextState != S_IDLE) && (w_nextState != S_HALTED);
      end
   end

   assign fetch_en    = r_fetchEn;
   assign decode_en   = r_decodeEn;
   assign execute_en  = r_executeEn;
   assign memory_en   = r_memoryEn;
   assign wb_en       = r_wbEn;
   assign pc_en       = r_pcEn;
   assign cc_we       = r_ccWe;
   assign stat        = r_stat;
   assign busy        = r_busy;
   assign instr_count = r_instrCount;

endmodule
